multi_blink: RTL and testbench
==============================

MULTI_BLINK -- requirements
Module: multi_blink

Interface
REQ-001 Parameter FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, time-base tick rate in Hz; DIV = FREQ/TICK_HZ cycles per tick.
REQ-003 Parameter CHANNELS, default 4, number of independent LED channels (1..16).
REQ-004 Parameter CNT_W, default 8, width of the per-channel half-period field in ticks.
REQ-005 Elaboration SHALL fail (fatal) if FREQ == 0, TICK_HZ == 0, DIV < 2, CHANNELS < 1, CHANNELS > 16 or CNT_W < 1.
REQ-006 Local CH_W = max(1, clog2(CHANNELS)).
REQ-007 clk_i  input  1  single clock; all state on its rising edge.
REQ-008 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-009 cfg_valid_i  input  1  configuration request.
REQ-010 cfg_ready_o  output  1  block can accept a configuration.
REQ-011 cfg_ch_i  input  CH_W  target channel index.
REQ-012 cfg_mode_i  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
REQ-013 cfg_half_i  input  CNT_W  half-period in ticks; 0 SHALL be treated as 1.
REQ-014 cfg_err_o  output  1  one-cycle pulse: accepted request had cfg_ch_i >= CHANNELS.
REQ-015 tick_o  output  1  one-cycle time-base pulse.
REQ-016 led_o  output  CHANNELS  LED drive, bit n = channel n.

Function
REQ-017 Prescaler counts 0..DIV-1 and wraps; tick_o SHALL be high exactly in the cycle the count equals DIV-1.
REQ-018 Transfer occurs on a rising edge with cfg_valid_i & cfg_ready_o; cfg_ready_o SHALL be low for exactly the one cycle after each transfer (apply cycle), otherwise high.
REQ-019 On transfer to a valid channel: mode, half and clearing of its tick counter and phase (to 0) SHALL take effect at that edge; led_o reflects the new config from the next cycle.
REQ-020 On transfer to an invalid channel: no channel state changes; cfg_err_o high in the following cycle only.
REQ-021 Per channel: tick counter 0..half-1; on tick_o at half-1, counter to 0 and phase advances; at other ticks counter increments.
REQ-022 BLINK: phase wraps 0..1; led = 1 in phase 0, 0 in phase 1 (period 2*half ticks, starts on).
REQ-023 BURST: phase wraps 0..8; led = 1 in phases 0, 2, 4, else 0 (three pulses, then 4-half gap; period 9*half ticks).
REQ-024 OFF: led = 0; ON: led = 1; counter and phase held at 0 in both.
REQ-025 led_o SHALL be decoded only from registered state; no combinational path from any input to any output.
REQ-026 Config transfer and tick_o in the same cycle for the same channel: config wins, counter and phase cleared, tick ignored for that channel.
REQ-027 Channels SHALL be fully independent; a transfer to one channel SHALL not disturb the counter or phase of any other.
REQ-028 Prescaler SHALL free-run; configuration SHALL never reset it.

Reset
REQ-029 While rst_ni low: prescaler 0, all channels OFF with counter/phase 0, led_o all 0, tick_o 0, cfg_err_o 0, cfg_ready_o 0.
REQ-030 cfg_ready_o SHALL rise at the first rising edge after rst_ni deasserts; reset asserted mid-pattern SHALL immediately force led_o to 0.

Verification
REQ-031 FREQ=1000, TICK_HZ=100, reset release -> tick_o every 10 cycles, first at cycle 9 after release; led_o = 0.
REQ-032 Ch0 BLINK half=3 -> led_o[0] 1 for 30 cycles, 0 for 30, repeating; other bits stay 0.
REQ-033 Ch1 BURST half=1 -> led_o[1] pattern 1,0,1,0,1,0,0,0,0 per tick, period 90 cycles.
REQ-034 Back-to-back cfg_valid_i on consecutive cycles -> second held off one cycle by cfg_ready_o=0, accepted next cycle.
REQ-035 cfg_ch_i=5 with CHANNELS=4 -> cfg_err_o single-cycle pulse, led_o unchanged; half=0 BLINK behaves as half=1.
REQ-036 rst_ni low mid-BURST for 3 cycles -> led_o 0 asynchronously, all channels OFF after release.

Source files
------------

// File: rtl/multi_blink_if.sv
// Configuration handshake bundle for multi_blink.
// Master drives requests, slave answers with ready and error pulse.
interface multi_blink_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 8
);
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [CH_W-1:0]  cfg_ch_i;
    logic [1:0]       cfg_mode_i;
    logic [CNT_W-1:0] cfg_half_i;
    logic             cfg_err_o;

    modport master (
        output cfg_valid_i,
        output cfg_ch_i,
        output cfg_mode_i,
        output cfg_half_i,
        input  cfg_ready_o,
        input  cfg_err_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_ch_i,
        input  cfg_mode_i,
        input  cfg_half_i,
        output cfg_ready_o,
        output cfg_err_o
    );
endinterface

// File: rtl/multi_blink.sv
// Multi-channel LED pattern generator on a shared tick time base.
// Each channel runs OFF, ON, BLINK or three-pulse BURST patterns.
module multi_blink #(
    parameter int FREQ     = 50_000_000,
    parameter int TICK_HZ  = 100,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    multi_blink_if.slave        cfg,
    output logic                tick_o,
    output logic [CHANNELS-1:0] led_o
);
    localparam int DIV  = FREQ / ((TICK_HZ == 0) ? 1 : TICK_HZ);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_BURST = 2'd3;

    if (FREQ == 0 || TICK_HZ == 0 || DIV < 2 ||
        CHANNELS < 1 || CHANNELS > 16 || CNT_W < 1) begin : g_bad_param
        $fatal(1, "multi_blink: illegal parameter set");
    end

    logic [PW-1:0] pre_q;
    logic          rdy_q;
    logic          err_q;
    logic          xfer;
    logic          bad_ch;

    assign xfer   = cfg.cfg_valid_i & rdy_q;
    assign bad_ch = int'(cfg.cfg_ch_i) >= CHANNELS;
    assign tick_o = (pre_q == PMAX);
    assign cfg.cfg_ready_o = rdy_q;
    assign cfg.cfg_err_o   = err_q;

    // Free-running prescaler; configuration never touches it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q <= '0;
        end else if (pre_q == PMAX) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Ready drops for the apply cycle after each transfer; error pulses once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rdy_q <= ~xfer;
            err_q <= xfer & bad_ch;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [1:0]       mode_q;
        logic [CNT_W-1:0] half_q;
        logic [CNT_W-1:0] cnt_q;
        logic [3:0]       ph_q;
        logic [3:0]       last;
        logic             hit;
        logic             wrap;
        logic             led;

        assign hit  = xfer && !bad_ch && (cfg.cfg_ch_i == CH_W'(c));
        assign last = (mode_q == M_BURST) ? 4'd8 : 4'd1;
        assign wrap = (cnt_q == half_q - 1'b1);

        // Per-channel tick counter and phase; a new config beats a same-cycle tick.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mode_q <= M_OFF;
                half_q <= CNT_W'(1);
                cnt_q  <= '0;
                ph_q   <= '0;
            end else if (hit) begin
                mode_q <= cfg.cfg_mode_i;
                half_q <= (cfg.cfg_half_i == '0) ? CNT_W'(1) : cfg.cfg_half_i;
                cnt_q  <= '0;
                ph_q   <= '0;
            end else if (mode_q == M_OFF || mode_q == M_ON) begin
                cnt_q  <= '0;
                ph_q   <= '0;
            end else if (tick_o) begin
                if (wrap) begin
                    cnt_q <= '0;
                    ph_q  <= (ph_q >= last) ? 4'd0 : ph_q + 4'd1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        // LED decoded purely from registered mode and phase.
        always_comb begin
            led = 1'b0;
            unique case (mode_q)
                M_OFF:   led = 1'b0;
                M_ON:    led = 1'b1;
                M_BLINK: led = (ph_q == 4'd0);
                M_BURST: led = (ph_q == 4'd0) || (ph_q == 4'd2) ||
                               (ph_q == 4'd4);
                default: led = 1'b0;
            endcase
        end

        assign led_o[c] = led;
    end
endmodule

// File: tb/tb_multi_blink.sv
// Randomised self-checking bench for multi_blink against a tick-count model.
// LED state is predicted from ticks elapsed since each channel's last config.
module tb_multi_blink;
    localparam int FREQ    = 1000;
    localparam int TICK_HZ = 100;
    localparam int CH      = 5;
    localparam int CNT_W   = 8;
    localparam int CH_W    = 3;
    localparam int DIV     = FREQ / TICK_HZ;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick;
    logic [CH-1:0] led;

    multi_blink_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    multi_blink #(
        .FREQ(FREQ), .TICK_HZ(TICK_HZ), .CHANNELS(CH), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .cfg(bus.slave),
        .tick_o(tick),
        .led_o(led)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    bit m_rdy;
    bit m_err;
    bit m_acc;
    int m_pre;
    int m_mode [CH];
    int m_half [CH];
    int m_t    [CH];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_led(int c);
        int p;
        case (m_mode[c])
            1: return 1'b1;
            2: return ((m_t[c] / m_half[c]) % 2) == 0;
            3: begin
                p = (m_t[c] / m_half[c]) % 9;
                return (p == 0) || (p == 2) || (p == 4);
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_leds();
        logic [31:0] v = '0;
        for (int c = 0; c < CH; c++) v[c] = exp_led(c);
        return v;
    endfunction

    task automatic model_reset();
        m_rdy = 0;
        m_err = 0;
        m_acc = 0;
        m_pre = 0;
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0;
            m_half[c] = 1;
            m_t[c]    = 0;
        end
    endtask

    task automatic model_step();
        bit tk;
        bit x;
        int ch;
        int h;
        ch = int'(bus.cfg_ch_i);
        h  = int'(bus.cfg_half_i);
        tk = (m_pre == DIV - 1);
        x  = bus.cfg_valid_i && m_rdy;
        m_acc = x;
        for (int c = 0; c < CH; c++) begin
            if (x && ch == c) begin
                m_mode[c] = int'(bus.cfg_mode_i);
                m_half[c] = (h == 0) ? 1 : h;
                m_t[c]    = 0;
            end else if (m_mode[c] >= 2 && tk) begin
                m_t[c]++;
            end
        end
        m_err = x && (ch >= CH);
        m_rdy = !x;
        m_pre = (m_pre + 1) % DIV;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        chk("led", 32'(led), exp_leds());
        chk("tick", 32'(tick), 32'(m_pre == DIV - 1));
        chk("ready", 32'(bus.cfg_ready_o), 32'(m_rdy));
        chk("err", 32'(bus.cfg_err_o), 32'(m_err));
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic send(int ch, int mode, int half, output int waited);
        bus.cfg_valid_i = 1'b1;
        bus.cfg_ch_i    = CH_W'(ch);
        bus.cfg_mode_i  = 2'(mode);
        bus.cfg_half_i  = CNT_W'(half);
        waited = 0;
        m_acc  = 0;
        while (!m_acc && waited < 4) begin
            cycle();
            waited++;
        end
        bus.cfg_valid_i = 1'b0;
        if (!m_acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int w1;
        int w2;
        bus.cfg_valid_i = 1'b0;
        bus.cfg_ch_i    = '0;
        bus.cfg_mode_i  = '0;
        bus.cfg_half_i  = '0;
        model_reset();

        idle(3);
        rst_n = 1'b1;
        idle(30);

        send(0, 2, 3, w1);
        idle(130);

        send(1, 3, 1, w1);
        idle(200);

        send(2, 1, 5, w1);
        send(3, 2, 2, w2);
        chk("first_wait", 32'(w1), 32'd1);
        chk("b2b_wait", 32'(w2), 32'd2);
        idle(60);

        send(5, 2, 4, w1);
        idle(20);

        send(4, 2, 0, w1);
        idle(40);

        repeat (40) begin
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), w1);
            idle(int'($urandom_range(0, 40)));
        end

        send(1, 3, 1, w1);
        idle(25);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led", 32'(led), 32'd0);
        chk("async_rdy", 32'(bus.cfg_ready_o), 32'd0);
        model_reset();
        idle(3);
        rst_n = 1'b1;
        idle(30);

        repeat (10) begin
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), w1);
            idle(int'($urandom_range(0, 30)));
        end
        idle(50);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
